// File: rtl/audio_fx_pkg.sv
// Shared definitions for the audio effect chain: sample/gain widths, the
// per-sample FSM encoding and the 16-bit saturation helper.
package audio_fx_pkg;

  localparam int SAMPLE_W = 16;
  localparam int GAIN_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_MIX,
    ST_WRITE
  } fx_state_e;

  // Clamp a one-bit-wider sum back into the signed 16-bit sample range.
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SAMPLE_W:0] x);
    logic signed [SAMPLE_W-1:0] r;
    if (x > 17'sd32767) begin
      r = 16'sh7fff;
    end else if (x < -17'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = x[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/echo_dpram.sv
// Delay-line storage for echo_delay: single-port synchronous RAM with a
// one-cycle registered read, written so that it maps onto block RAM.
module echo_dpram
  import audio_fx_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = SAMPLE_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem_q[addr];
    end
  end

endmodule

// File: rtl/echo_delay.sv
// Per-sample echo stage: circular delay line plus gain-scaled wet mix.
// Define ECHO_FEEDBACK_EN to recirculate the delayed signal into the buffer.
module echo_delay
  import audio_fx_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] audio_in,
  input  logic                       en,
  input  logic [ADDR_W-1:0]          delay_len,
  input  logic [GAIN_W-1:0]          mix_gain,
  input  logic [GAIN_W-1:0]          fb_gain,
  output logic signed [SAMPLE_W-1:0] audio_out,
  output logic                       out_valid,
  output logic                       overrun
);

  // Q0.8 gain: 24-bit signed product, arithmetic shift rounds toward -inf.
  function automatic logic signed [SAMPLE_W-1:0] scale_q08(
    input logic signed [SAMPLE_W-1:0] d,
    input logic [GAIN_W-1:0]          g
  );
    logic signed [23:0] prod;
    prod = 24'(d) * 24'($signed({1'b0, g}));
    return 16'(prod >>> 8);
  endfunction

  fx_state_e state_q, state_d;
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic overrun_q, overrun_d;
  logic out_valid_q, out_valid_d;
  logic signed [SAMPLE_W-1:0] audio_out_q, audio_out_d;

  logic signed [SAMPLE_W-1:0] smp_q, smp_d;
  logic en_q, en_d;
  logic [ADDR_W-1:0] dly_q, dly_d;
  logic [GAIN_W-1:0] mix_q, mix_d;
  logic signed [SAMPLE_W-1:0] wet_q, wet_d;
`ifdef ECHO_FEEDBACK_EN
  logic [GAIN_W-1:0] fb_q, fb_d;
  logic signed [SAMPLE_W-1:0] fbk_q, fbk_d;
`else
  logic unused_fb_gain;
  assign unused_fb_gain = ^fb_gain;
`endif

  logic ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [SAMPLE_W-1:0] ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] dly_eff;
  logic signed [SAMPLE_W-1:0] d_dly;

  echo_dpram #(
    .ADDR_W(ADDR_W),
    .DATA_W(SAMPLE_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign dly_eff = (delay_len == '0) ? ADDR_W'(1) : delay_len;
  // Until enough samples are written, the read slot holds pre-reset garbage.
  assign d_dly = (fill_q < dly_q) ? '0 : $signed(ram_rdata);

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    fill_d      = fill_q;
    overrun_d   = overrun_q;
    out_valid_d = 1'b0;
    audio_out_d = audio_out_q;
    smp_d       = smp_q;
    en_d        = en_q;
    dly_d       = dly_q;
    mix_d       = mix_q;
    wet_d       = wet_q;
`ifdef ECHO_FEEDBACK_EN
    fb_d        = fb_q;
    fbk_d       = fbk_q;
`endif
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = wp_q - dly_q;
    ram_wdata   = smp_q;

    if (sample_valid && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (sample_valid) begin
          smp_d   = audio_in;
          en_d    = en;
          dly_d   = dly_eff;
          mix_d   = mix_gain;
`ifdef ECHO_FEEDBACK_EN
          fb_d    = fb_gain;
`endif
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        ram_re  = 1'b1;
        state_d = ST_MIX;
      end
      ST_MIX: begin
        wet_d   = scale_q08(d_dly, mix_q);
`ifdef ECHO_FEEDBACK_EN
        fbk_d   = scale_q08(d_dly, fb_q);
`endif
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        ram_we      = 1'b1;
        ram_addr    = wp_q;
`ifdef ECHO_FEEDBACK_EN
        ram_wdata   = sat16(17'(smp_q) + 17'(fbk_q));
`else
        ram_wdata   = smp_q;
`endif
        out_valid_d = 1'b1;
        audio_out_d = en_q ? sat16(17'(smp_q) + 17'(wet_q)) : smp_q;
        wp_d        = wp_q + ADDR_W'(1);
        if (fill_q != '1) begin
          fill_d = fill_q + ADDR_W'(1);
        end
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wp_q        <= '0;
      fill_q      <= '0;
      overrun_q   <= 1'b0;
      out_valid_q <= 1'b0;
      audio_out_q <= '0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      fill_q      <= fill_d;
      overrun_q   <= overrun_d;
      out_valid_q <= out_valid_d;
      audio_out_q <= audio_out_d;
    end
  end

  // Sample and product registers carry data only; the FSM qualifies them.
  always_ff @(posedge clk) begin
    smp_q <= smp_d;
    en_q  <= en_d;
    dly_q <= dly_d;
    mix_q <= mix_d;
    wet_q <= wet_d;
`ifdef ECHO_FEEDBACK_EN
    fb_q  <= fb_d;
    fbk_q <= fbk_d;
`endif
  end

  assign audio_out = audio_out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_echo_delay.sv
// Directed bench for echo_delay (ADDR_W=4 so the pointer wraps quickly).
module tb_echo_delay;
  localparam int AW = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               sample_valid = 1'b0;
  logic signed [15:0] audio_in = '0;
  logic               en = 1'b1;
  logic [AW-1:0]      delay_len = '0;
  logic [7:0]         mix_gain = '0;
  logic [7:0]         fb_gain = '0;
  logic signed [15:0] audio_out;
  logic               out_valid;
  logic               overrun;

  int total = 0;
  int bad = 0;

  echo_delay #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_valid(sample_valid),
    .audio_in    (audio_in),
    .en          (en),
    .delay_len   (delay_len),
    .mix_gain    (mix_gain),
    .fb_gain     (fb_gain),
    .audio_out   (audio_out),
    .out_valid   (out_valid),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Strobe one sample; result must appear exactly three edges later.
  task automatic send(input logic signed [15:0] x, input logic signed [15:0] exp,
                      input string tag, input bit check);
    sample_valid = 1'b1;
    audio_in     = x;
    tick();
    sample_valid = 1'b0;
    tick();
    if (check) chk({tag, "_ov_n1"}, 32'(out_valid), 32'(0));
    tick();
    if (check) chk({tag, "_ov_n2"}, 32'(out_valid), 32'(0));
    tick();
    if (check) begin
      chk({tag, "_ov_n3"}, 32'(out_valid), 32'(1));
      chk({tag, "_out"}, 32'(audio_out), 32'(exp));
    end
  endtask

  initial begin
    int imp_exp[9];
    int fb_exp[7];
    int nvalid;
    int vout;
    logic signed [15:0] x;

    imp_exp = '{1000, 0, 0, 0, 500, 0, 0, 0, 0};
`ifdef ECHO_FEEDBACK_EN
    fb_exp = '{16384, 0, 16320, 0, 8160, 0, 4080};
`else
    fb_exp = '{16384, 0, 16320, 0, 0, 0, 0};
`endif

    tick();
    tick();
    chk("rst_out", 32'(audio_out), 32'(0));
    chk("rst_ov", 32'(out_valid), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
    reset_n = 1'b1;
    tick();

    // Impulse
    do_reset();
    en = 1'b1; delay_len = 4'd4; mix_gain = 8'd128;
    for (int i = 0; i < 9; i++) begin
      x = (i == 0) ? 16'sd1000 : 16'sd0;
      send(x, 16'(imp_exp[i]), $sformatf("imp%0d", i), 1'b1);
    end

    // Feedback (single echo when feedback is not compiled in)
    do_reset();
    delay_len = 4'd2; mix_gain = 8'd255; fb_gain = 8'd128;
    for (int i = 0; i < 7; i++) begin
      x = (i == 0) ? 16'sd16384 : 16'sd0;
      send(x, 16'(fb_exp[i]), $sformatf("fb%0d", i), 1'b1);
    end

    // Saturation in both directions; delay_len=0 behaves as 1
    do_reset();
    delay_len = 4'd0; mix_gain = 8'd255; fb_gain = 8'd0;
    send(16'sd30000, 16'sd30000, "sat0", 1'b1);
    send(16'sd30000, 16'sd32767, "sat_pos", 1'b1);
    send(-16'sd30000, -16'sd118, "sat_mid", 1'b1);
    send(-16'sd30000, -16'sd32768, "sat_neg", 1'b1);

    // Overrun: two consecutive strobes, second is dropped
    do_reset();
    delay_len = 4'd4; mix_gain = 8'd128;
    sample_valid = 1'b1; audio_in = 16'sd123;
    tick();
    audio_in = 16'sd456;
    tick();
    sample_valid = 1'b0;
    nvalid = 0; vout = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) begin
        nvalid++;
        vout = int'(audio_out);
      end
      tick();
    end
    chk("ovr_count", 32'(nvalid), 32'(1));
    chk("ovr_value", 32'(vout), 32'(123));
    chk("ovr_flag", 32'(overrun), 32'(1));
    send(16'sd7, 16'sd7, "ovr_after", 1'b1);
    chk("ovr_sticky", 32'(overrun), 32'(1));
    do_reset();
    chk("ovr_clear", 32'(overrun), 32'(0));

    // Reset mid-operation abandons the sample
    sample_valid = 1'b1; audio_in = 16'sd999;
    tick();
    sample_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) nvalid++;
    end
    chk("midrst_noval", 32'(nvalid), 32'(0));
    chk("midrst_overrun", 32'(overrun), 32'(0));

    // Fill guard: scribble random data over the whole buffer, then reset
    do_reset();
    delay_len = 4'd1; mix_gain = 8'd0;
    for (int i = 0; i < 16; i++) begin
      x = 16'($urandom);
      send(x, 16'sd0, "pre", 1'b0);
    end
    do_reset();
    delay_len = 4'd8; mix_gain = 8'd255;
    for (int i = 1; i <= 8; i++) begin
      send(16'(i), 16'(i), $sformatf("fill%0d", i), 1'b1);
    end

    // Wrap: 40-sample ramp through a 16-entry buffer with delay 15
    do_reset();
    en = 1'b1; delay_len = 4'd15; mix_gain = 8'd255;
    for (int n = 1; n <= 40; n++) begin
      int m;
      int e;
      m = n - 15;
      e = (m >= 1) ? n + ((m * 255) >>> 8) : n;
      send(16'(n), 16'(e), $sformatf("wrap%0d", n), 1'b1);
    end

    // Bypass: output equals input despite non-zero delayed data
    en = 1'b0;
    for (int n = 41; n <= 45; n++) begin
      send(16'(n), 16'(n), $sformatf("byp%0d", n), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/echo_delay.md
# echo_delay

Feedback echo stage sitting directly downstream of the distortion effect in the audio effect chain. It stores the incoming 16-bit signed sample stream in a circular delay line held in on-chip block RAM and mixes a gain-scaled delayed copy back into the output. It optionally recirculates the delayed signal into the buffer. Processing is strobed per sample, so one echo instance serves any sample rate well below the system clock.

## Interface
- ADDR_W, 12: delay-line address width; buffer depth 2^ADDR_W samples (4096 by default).
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sample_valid  in  1  one-cycle strobe qualifying audio_in.
- audio_in  in  16  signed sample from the distortion stage.
- en  in  1  1 = echo applied; 0 = bypass.
- delay_len  in  ADDR_W  echo delay in samples; value 0 is treated as 1.
- mix_gain  in  8  wet gain, unsigned Q0.8 (value/256).
- fb_gain  in  8  feedback gain, unsigned Q0.8. Ignored unless feedback is compiled in.
- audio_out  out  16  signed processed sample (registered).
- out_valid  out  1  one-cycle strobe when audio_out updates.
- overrun  out  1  sticky flag: a sample_valid arrived while the block was busy.

## Operation
- FSM states: IDLE, READ, MIX, WRITE.
  - IDLE: on sample_valid, latch audio_in, en, delay_len, mix_gain and fb_gain, then go to READ.
  - READ: present read address rd = (wp - max(delay_len,1)) mod 2^ADDR_W, then go to MIX.
  - MIX: RAM data is valid. Compute the products, then go to WRITE.
  - WRITE: write the buffer word at wp, update the outputs, increment wp (wraps 2^ADDR_W-1 -> 0), return to IDLE.
- sample_valid outside IDLE: the sample is dropped, overrun is set and stays set until reset, and the FSM is unaffected.
- Fill tracking: counter fill increments per written sample and saturates at 2^ADDR_W-1.
  - d = 0 while fill < max(delay_len,1); otherwise d = RAM read data.
  - Uninitialised RAM content therefore never reaches the output.
- Wet path: wet = (d * mix_gain) >>> 8, using a 24-bit signed product and an arithmetic shift (rounds toward -inf).
- Output:
  - en=1: audio_out = sat16(audio_in + wet).
  - en=0: audio_out = audio_in. The buffer is still written, so switching en never replays stale data.
- sat16 clamps to the range [-32768, 32767].
- Buffer write value: see Configuration.
- delay_len changes take effect only at the next latched sample. Changes never corrupt the buffer.

## Timing
- Reset values: audio_out=0, out_valid=0, overrun=0, wp=0, fill=0, state=IDLE. RAM contents are not cleared.
- Latency: sample_valid is sampled high at edge N. audio_out and out_valid=1 are updated at edge N+3. out_valid is high for exactly one cycle.
- Minimum sample spacing is 4 clocks. A strobe exactly at edge N+4 is accepted.
- RAM: synchronous read with one-cycle latency. The write at wp and the read at rd never occur in the same cycle.
- Reset mid-operation: the in-flight sample is abandoned, no RAM write occurs, and no out_valid is produced.

## Configuration
- ECHO_FEEDBACK_EN defined: the buffer is written with sat16(audio_in + ((d * fb_gain) >>> 8)), giving decaying repeated echoes.
- ECHO_FEEDBACK_EN undefined: the buffer is written with audio_in, giving a single echo. fb_gain is unused and its multiplier is not synthesised.

## Structure
- Shared package audio_fx_pkg holds:
  - SAMPLE_W=16 and GAIN_W=8;
  - the FSM state encoding;
  - the sat16 function, reused by other effect stages.
- One sub-module, echo_dpram: a simple synchronous single-port RAM, 16 x 2^ADDR_W, one-cycle read latency, inferred to Gowin BSRAM.

## Test plan
- Impulse: delay_len=4, mix=128, feedback off, en=1. Input 1000 followed by zeros. Required outputs: 1000, 0, 0, 0, 500, then zeros.
- Feedback (macro on): delay_len=2, mix=255, fb=128. Input 16384 followed by zeros. Required outputs: 16384, 0, 16320, 0, 8160, 0, 4080.
- Saturation: delayed sample 30000, mix=255, input 30000 -> output 32767. Delayed -30000, input -30000 -> output -32768.
- Fill guard: preload the RAM with random data, reset, set delay_len=8, feed a ramp 1..8. The first 8 outputs must equal the inputs exactly.
- Overrun: sample_valid on two consecutive cycles -> exactly one out_valid, and overrun=1 persists until reset_n pulses low.
- Wrap and bypass: ADDR_W=4, delay_len=15, mix=256-1, feed 40 ramp samples. Output n must equal n + ((n-15)*255>>>8) across the wp wrap. Then set en=0: outputs equal the inputs with 3-cycle latency.
